// File: rtl/icetap_data_readout.sv
// Streams capture-RAM words LSB-first onto the data scan chain, fetching one word per boundary.
// Define ICETAP_DATA_PREFETCH_EN to add a one-word prefetch buffer for gap-free shifting.
module icetap_data_readout #(
    parameter int NR_SIGNALS   = 16,
    parameter int RECORD_DEPTH = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic                  scan_clk,
    input  logic                  scan_reset_,
    input  logic                  data_shift_update,
    input  logic                  data_shift_ena,
    output logic                  data_shift_data,
    output logic                  read_req_first,
    output logic                  read_req_next,
    input  logic [NR_SIGNALS-1:0] read_data,
    output logic                  readout_done,
    output logic                  readout_underrun
);

    localparam int WORD_BITS     = 8 * ((NR_SIGNALS + 7) / 8);
    localparam int RAM_ADDR_BITS = $clog2(RECORD_DEPTH);
    localparam int WC_W          = RAM_ADDR_BITS + 1;
    localparam int BC_W          = $clog2(WORD_BITS);
    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(WORD_BITS - 1);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(RECORD_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t                  state_q;
    logic [WORD_BITS-1:0]    shreg_q;
    logic [BC_W-1:0]         bit_cntr_q;
    logic [WC_W-1:0]         word_cntr_q;
    logic [READ_LATENCY-1:0] pipe_q;
    logic [READ_LATENCY-1:0] pipe_d;
    logic                    req_first_q;
    logic                    req_next_q;
    logic                    done_q;
    logic                    underrun_q;
`ifdef ICETAP_DATA_PREFETCH_EN
    logic [WORD_BITS-1:0]    nxt_buf_q;
    logic                    nxt_valid_q;
`endif

    logic                 token_exit;
    logic                 more_words;
    logic [WORD_BITS-1:0] rd_word;

    // Token pipe mirrors the RAM read latency; a token leaving marks read_data valid.
    assign pipe_d[0] = req_first_q | req_next_q;
    generate
        for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
            assign pipe_d[gi] = pipe_q[gi-1];
        end
    endgenerate

    assign token_exit = pipe_q[READ_LATENCY-1];
    assign more_words = (word_cntr_q != LAST_WORD);
    assign rd_word    = WORD_BITS'(read_data);

    assign data_shift_data  = shreg_q[0];
    assign read_req_first   = req_first_q;
    assign read_req_next    = req_next_q;
    assign readout_done     = done_q;
    assign readout_underrun = underrun_q;

    always_ff @(posedge scan_clk) begin
        if (!scan_reset_) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cntr_q  <= '0;
            word_cntr_q <= '0;
            pipe_q      <= '0;
            req_first_q <= 1'b0;
            req_next_q  <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef ICETAP_DATA_PREFETCH_EN
            nxt_buf_q   <= '0;
            nxt_valid_q <= 1'b0;
`endif
        end else if (data_shift_update) begin
            // Restart wins over any token exit or shift in the same cycle.
            state_q     <= FETCH;
            shreg_q     <= '0;
            bit_cntr_q  <= '0;
            word_cntr_q <= '0;
            pipe_q      <= '0;
            req_first_q <= 1'b1;
            req_next_q  <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef ICETAP_DATA_PREFETCH_EN
            nxt_valid_q <= 1'b0;
`endif
        end else begin
            req_first_q <= 1'b0;
            req_next_q  <= 1'b0;
            pipe_q      <= pipe_d;
            case (state_q)
                IDLE, DONE: begin
                end
                FETCH: begin
                    if (data_shift_ena) begin
                        underrun_q <= 1'b1;
                    end
                    if (token_exit) begin
                        shreg_q <= rd_word;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
`ifdef ICETAP_DATA_PREFETCH_EN
                    if (token_exit) begin
                        nxt_buf_q   <= rd_word;
                        nxt_valid_q <= 1'b1;
                    end
                    if (data_shift_ena && bit_cntr_q == '0 && more_words) begin
                        req_next_q <= 1'b1;
                    end
`endif
                    if (data_shift_ena) begin
                        shreg_q    <= shreg_q >> 1;
                        bit_cntr_q <= bit_cntr_q + 1'b1;
                        if (bit_cntr_q == LAST_BIT) begin
                            bit_cntr_q  <= '0;
                            word_cntr_q <= word_cntr_q + 1'b1;
                            if (!more_words) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
`ifdef ICETAP_DATA_PREFETCH_EN
                                // Prefer the buffered word; a word arriving this very cycle bypasses the buffer.
                                if (nxt_valid_q) begin
                                    shreg_q     <= nxt_buf_q;
                                    nxt_valid_q <= 1'b0;
                                end else if (token_exit) begin
                                    shreg_q     <= rd_word;
                                    nxt_valid_q <= 1'b0;
                                end else begin
                                    state_q <= FETCH;
                                end
`else
                                req_next_q <= 1'b1;
                                state_q    <= FETCH;
`endif
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icetap_data_readout.sv
// Scoreboard bench: expected serial bits are queued by stimulus and checked by a negedge monitor.
module tb_icetap_data_readout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, upd, ena, dout, rqf, rqn, done, und;
    logic [15:0] rdata;
    logic        upd12, ena12, dout12, rqf12, rqn12, done12, und12;
    logic [11:0] rdata12;

    int checks = 0;
    int failures = 0;

    icetap_data_readout #(.NR_SIGNALS(16), .RECORD_DEPTH(4), .READ_LATENCY(2)) dut (
        .scan_clk(clk), .scan_reset_(rst_n), .data_shift_update(upd), .data_shift_ena(ena),
        .data_shift_data(dout), .read_req_first(rqf), .read_req_next(rqn), .read_data(rdata),
        .readout_done(done), .readout_underrun(und));

    icetap_data_readout #(.NR_SIGNALS(12), .RECORD_DEPTH(2), .READ_LATENCY(2)) dut12 (
        .scan_clk(clk), .scan_reset_(rst_n), .data_shift_update(upd12), .data_shift_ena(ena12),
        .data_shift_data(dout12), .read_req_first(rqf12), .read_req_next(rqn12), .read_data(rdata12),
        .readout_done(done12), .readout_underrun(und12));

    // Capture RAM model: data valid two cycles after a request, address wraps at depth.
    logic [15:0] mem [4];
    logic [15:0] s1;
    int          cur;
    initial begin
        mem = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hFFFF};
        rdata12 = 12'hABC;
        cur = 0;
        s1 = '0;
        rdata = '0;
    end
    always @(posedge clk) begin
        if (rqf) begin
            cur = 0;
            s1 <= mem[0];
        end else if (rqn) begin
            cur = (cur + 1) % 4;
            s1 <= mem[cur];
        end
        rdata <= s1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("check %s: 0x%0h ok", name, act);
        end
    endtask

    logic qexp[$];
    logic q12[$];
    int   req_pos[$];
    int   n_first = 0, n_next = 0, bits_seen = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rqf || rqn) check("req_exclusive", {31'b0, rqf & rqn}, 32'd0);
            if (rqf) n_first++;
            if (rqn) begin
                n_next++;
                req_pos.push_back(bits_seen);
            end
            if (ena) begin
                if (qexp.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else check($sformatf("bit%0d", bits_seen), {31'b0, dout}, {31'b0, qexp.pop_front()});
                bits_seen++;
            end
            if (ena12) begin
                if (q12.size() == 0) check("sb12_underflow", 32'd1, 32'd0);
                else check("bit12", {31'b0, dout12}, {31'b0, q12.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic update();
        upd = 1'b1;
        tick(1);
        upd = 1'b0;
    endtask

    task automatic shift_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ena = 1'b1;
            qexp.push_back(w[i]);
            tick(1);
        end
        ena = 1'b0;
    endtask

    task automatic full_readout_with_gaps();
        for (int k = 0; k < 4; k++) begin
            shift_bits(mem[k], 16);
            tick(4);
            if (k == 2) check("done_early", {31'b0, done}, 32'd0);
        end
    endtask

    int bf, bn, b0;

    initial begin
        rst_n = 1'b0; upd = 1'b0; ena = 1'b0; upd12 = 1'b0; ena12 = 1'b0;
        tick(3);
        check("rst_dout", {31'b0, dout}, 32'd0);
        check("rst_reqs", {30'b0, rqf, rqn}, 32'd0);
        check("rst_done_und", {30'b0, done, und}, 32'd0);
        rst_n = 1'b1;
        tick(1);

        // 12-bit samples pad to a 16-bit word with zeros on top.
        upd12 = 1'b1; tick(1); upd12 = 1'b0;
        tick(4);
        begin
            logic [15:0] w12;
            w12 = 16'h0ABC;
            for (int i = 0; i < 16; i++) begin
                ena12 = 1'b1;
                q12.push_back(w12[i]);
                tick(1);
            end
            ena12 = 1'b0;
        end
        tick(2);
        check("w12_und", {31'b0, und12}, 32'd0);
        check("w12_done", {31'b0, done12}, 32'd0);

        // Full readout with idle gaps at word boundaries.
        bf = n_first; bn = n_next;
        update();
        tick(4);
        full_readout_with_gaps();
        check("t1_req_first", n_first - bf, 32'd1);
        check("t1_req_next", n_next - bn, 32'd3);
        check("t1_done", {31'b0, done}, 32'd1);
        check("t1_und", {31'b0, und}, 32'd0);

        // Shifting in DONE yields zeros and no requests.
        bf = n_first; bn = n_next;
        shift_bits(16'h0000, 10);
        tick(2);
        check("t5_reqs", (n_first - bf) + (n_next - bn), 32'd0);
        check("t5_done", {31'b0, done}, 32'd1);
        check("t5_und", {31'b0, und}, 32'd0);

        // Shift before the first word arrives -> underrun, zeros, word still complete.
        update();
        shift_bits(16'h0000, 2);
        tick(3);
        check("t3_und", {31'b0, und}, 32'd1);
        shift_bits(mem[0], 16);
        tick(4);
        shift_bits(mem[1], 16);
        tick(4);
        shift_bits(mem[2], 5);

        // Restart mid-word 2: flags clear and readout begins again at word 0.
        bf = n_first; bn = n_next;
        update();
        check("t4_und_clr", {31'b0, und}, 32'd0);
        check("t4_done_clr", {31'b0, done}, 32'd0);
        tick(4);
        full_readout_with_gaps();
        check("t4_req_first", n_first - bf, 32'd1);
        check("t4_req_next", n_next - bn, 32'd3);
        check("t4_done", {31'b0, done}, 32'd1);
        check("t4_und", {31'b0, und}, 32'd0);

`ifdef ICETAP_DATA_PREFETCH_EN
        // Continuous shifting with prefetch: no gaps, requests after each word's first bit.
        update();
        req_pos.delete();
        tick(4);
        b0 = bits_seen;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) begin
                ena = 1'b1;
                qexp.push_back(mem[k][i]);
                tick(1);
            end
        end
        ena = 1'b0;
        tick(4);
        check("t6_nreq", req_pos.size(), 32'd3);
        if (req_pos.size() == 3) begin
            check("t6_pos0", req_pos[0] - b0, 32'd1);
            check("t6_pos1", req_pos[1] - b0, 32'd17);
            check("t6_pos2", req_pos[2] - b0, 32'd33);
        end
        check("t6_und", {31'b0, und}, 32'd0);
        check("t6_done", {31'b0, done}, 32'd1);
`endif

        check("sb_drained", qexp.size(), 32'd0);
        check("sb12_drained", q12.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
